// File: rtl/spec_pkg.sv
// Shared speculation helpers: spec-level width, branch-resolution remap and squash predicate.
package spec_pkg;

    localparam int unsigned SPEC_DEPTH     = 4;
    localparam int unsigned SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1;
    localparam int unsigned SPEC_TBL_BIT   = SPEC_LEVEL_BIT * (SPEC_DEPTH + 1);

    // Levels beyond the table are left untouched.
    function automatic logic [SPEC_LEVEL_BIT-1:0] spec_remap(
        input logic [SPEC_LEVEL_BIT-1:0] level,
        input logic [SPEC_TBL_BIT-1:0]   tbl
    );
        logic [SPEC_LEVEL_BIT-1:0] res;
        res = level;
        for (int unsigned i = 0; i <= SPEC_DEPTH; i++) begin
            if (level == SPEC_LEVEL_BIT'(i)) begin
                res = tbl[i*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
            end
        end
        return res;
    endfunction

    function automatic logic spec_squash(
        input logic [SPEC_LEVEL_BIT-1:0] level,
        input logic [SPEC_LEVEL_BIT-1:0] fail_level
    );
        return level >= fail_level;
    endfunction

endpackage

// File: rtl/spec_pipe_reg.sv
// One speculative pipeline stage: valid bit, spec level and payload, with
// squash-on-fail and remap-on-succ applied to whatever the stage holds next.
module spec_pipe_reg
    import spec_pkg::*;
#(
    parameter int unsigned PAYLOAD_BIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_en,
    input  logic                      ld_vld,
    input  logic [PAYLOAD_BIT-1:0]    ld_payload,
    input  logic [SPEC_LEVEL_BIT-1:0] ld_level,
    input  logic                      br_fail,
    input  logic                      br_succ,
    input  logic [SPEC_LEVEL_BIT-1:0] br_fail_level,
    input  logic [SPEC_TBL_BIT-1:0]   br_nxt_levels,
    output logic                      vld,
    output logic [PAYLOAD_BIT-1:0]    payload,
    output logic [SPEC_LEVEL_BIT-1:0] level,
    output logic                      squash_c
);

    logic                      vld_q, vld_d;
    logic [PAYLOAD_BIT-1:0]    payload_q, payload_d;
    logic [SPEC_LEVEL_BIT-1:0] level_q, level_d;
    logic                      src_vld;
    logic [SPEC_LEVEL_BIT-1:0] src_level;

    // Resolution applies to the entry the stage will hold after the edge.
    always_comb begin
        src_vld   = vld_q;
        src_level = level_q;
        payload_d = payload_q;
        if (ld_en) begin
            src_vld   = ld_vld;
            src_level = ld_level;
            payload_d = ld_payload;
        end
        vld_d   = src_vld && !(br_fail && spec_squash(src_level, br_fail_level));
        level_d = br_succ ? spec_remap(src_level, br_nxt_levels) : src_level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            payload_q <= '0;
            level_q   <= '0;
        end else begin
            vld_q     <= vld_d;
            payload_q <= payload_d;
            level_q   <= level_d;
        end
    end

    assign vld      = vld_q;
    assign payload  = payload_q;
    assign level    = level_q;
    assign squash_c = br_fail && vld_q && spec_squash(level_q, br_fail_level);

endmodule

// File: rtl/store_fu.sv
// Store functional unit: two-stage pipe computing base + sign-extended offset and
// handing stores to store_buf with same-cycle squash gating and level remap.
module store_fu
    import spec_pkg::*;
#(
    parameter int unsigned INST_ID_BIT = 8,
    parameter int unsigned ADDR_BIT    = 16,
    parameter int unsigned DATA_BIT    = 16,
    parameter int unsigned OFS_BIT     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [INST_ID_BIT-1:0]    in_id,
    input  logic [ADDR_BIT-1:0]       in_base,
    input  logic [OFS_BIT-1:0]        in_ofs,
    input  logic [DATA_BIT-1:0]       in_data,
    input  logic [SPEC_LEVEL_BIT-1:0] in_spec_level,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [INST_ID_BIT-1:0]    out_id,
    output logic [ADDR_BIT-1:0]       out_addr,
    output logic [DATA_BIT-1:0]       out_data,
    output logic [SPEC_LEVEL_BIT-1:0] out_spec_level,
    output logic                      done_vld,
    output logic [INST_ID_BIT-1:0]    done_id,
    input  logic                      br_pred_vld,
    input  logic                      br_pred_succ,
    input  logic [SPEC_LEVEL_BIT-1:0] br_pred_fail_level,
    input  logic [SPEC_TBL_BIT-1:0]   br_pred_succ_nxt_levels
);

    localparam int unsigned A_BIT = INST_ID_BIT + DATA_BIT + ADDR_BIT + OFS_BIT;
    localparam int unsigned B_BIT = INST_ID_BIT + DATA_BIT + ADDR_BIT;

    logic                      br_fail_c, br_succ_c;
    logic                      a_vld, a_sq_c, b_vld, b_sq_c, b_free_c;
    logic [A_BIT-1:0]          a_payload;
    logic [B_BIT-1:0]          b_payload;
    logic [SPEC_LEVEL_BIT-1:0] a_level, b_level;
    logic [INST_ID_BIT-1:0]    a_id;
    logic [DATA_BIT-1:0]       a_data;
    logic [ADDR_BIT-1:0]       a_base, addr_c;
    logic [OFS_BIT-1:0]        a_ofs;

    assign br_fail_c = br_pred_vld && !br_pred_succ;
    assign br_succ_c = br_pred_vld && br_pred_succ;

    assign {a_id, a_data, a_base, a_ofs} = a_payload;
    assign addr_c = a_base + ADDR_BIT'($signed(a_ofs));

    // Combinational ready chain: B frees on handshake or squash, A follows.
    assign out_vld  = b_vld && !b_sq_c;
    assign done_vld = out_vld && out_rdy;
    assign b_free_c = !b_vld || done_vld || b_sq_c;
    assign in_rdy   = !a_vld || b_free_c || a_sq_c;

    spec_pipe_reg #(.PAYLOAD_BIT(A_BIT)) u_stage_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_en         (in_rdy),
        .ld_vld        (in_vld),
        .ld_payload    ({in_id, in_data, in_base, in_ofs}),
        .ld_level      (in_spec_level),
        .br_fail       (br_fail_c),
        .br_succ       (br_succ_c),
        .br_fail_level (br_pred_fail_level),
        .br_nxt_levels (br_pred_succ_nxt_levels),
        .vld           (a_vld),
        .payload       (a_payload),
        .level         (a_level),
        .squash_c      (a_sq_c)
    );

    spec_pipe_reg #(.PAYLOAD_BIT(B_BIT)) u_stage_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_en         (b_free_c),
        .ld_vld        (a_vld),
        .ld_payload    ({a_id, a_data, addr_c}),
        .ld_level      (a_level),
        .br_fail       (br_fail_c),
        .br_succ       (br_succ_c),
        .br_fail_level (br_pred_fail_level),
        .br_nxt_levels (br_pred_succ_nxt_levels),
        .vld           (b_vld),
        .payload       (b_payload),
        .level         (b_level),
        .squash_c      (b_sq_c)
    );

    assign {out_id, out_data, out_addr} = b_payload;
    assign out_spec_level = br_succ_c ? spec_remap(b_level, br_pred_succ_nxt_levels) : b_level;
    assign done_id        = out_id;

endmodule

// File: tb/tb_store_fu.sv
// Bench for store_fu: queue-based reference model of in-flight stores checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_store_fu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld, in_rdy, out_vld, out_rdy, done_vld;
    logic [7:0]  in_id, out_id, done_id, in_ofs;
    logic [15:0] in_base, in_data, out_addr, out_data;
    logic [2:0]  in_spec_level, out_spec_level, br_pred_fail_level;
    logic        br_pred_vld, br_pred_succ;
    logic [14:0] br_pred_succ_nxt_levels;

    always #5 clk = ~clk;

    store_fu dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_id(in_id), .in_base(in_base),
        .in_ofs(in_ofs), .in_data(in_data), .in_spec_level(in_spec_level),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_addr(out_addr),
        .out_data(out_data), .out_spec_level(out_spec_level),
        .done_vld(done_vld), .done_id(done_id),
        .br_pred_vld(br_pred_vld), .br_pred_succ(br_pred_succ),
        .br_pred_fail_level(br_pred_fail_level),
        .br_pred_succ_nxt_levels(br_pred_succ_nxt_levels)
    );

    typedef struct {
        logic [7:0]  id;
        logic [15:0] addr;
        logic [15:0] data;
        int          level;
        int          age;
    } st_t;

    st_t        mq[$];
    logic [7:0] emitted[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         exp_in_rdy, exp_done;

    function automatic int nxt_of(int l);
        if (l > 4) return l;
        return int'((br_pred_succ_nxt_levels >> (3 * l)) & 15'h7);
    endfunction

    function automatic bit sq(int l);
        return br_pred_vld && !br_pred_succ && (l >= int'(br_pred_fail_level));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model view: head of queue aged >= 2 sits in the output stage.
    task automatic settle_check();
        bit ov;
        #1;
        ov = mq.size() > 0 && mq[0].age >= 2 && !sq(mq[0].level);
        exp_done = ov && out_rdy;
        exp_in_rdy = mq.size() < 2 || exp_done ||
                     (mq.size() > 0 && sq(mq[0].level)) ||
                     (mq.size() > 1 && sq(mq[1].level));
        chk("out_vld", 32'(out_vld), 32'(ov));
        chk("done_vld", 32'(done_vld), 32'(exp_done));
        chk("in_rdy", 32'(in_rdy), 32'(exp_in_rdy));
        if (ov) begin
            chk("out_id", 32'(out_id), 32'(mq[0].id));
            chk("out_addr", 32'(out_addr), 32'(mq[0].addr));
            chk("out_data", 32'(out_data), 32'(mq[0].data));
            chk("out_spec_level", 32'(out_spec_level),
                32'(br_pred_vld && br_pred_succ ? nxt_of(mq[0].level) : mq[0].level));
        end
        if (exp_done) chk("done_id", 32'(done_id), 32'(mq[0].id));
        if (rst_n && done_vld) emitted.push_back(done_id);
    endtask

    task automatic advance();
        st_t nq[$];
        st_t e;
        bit  succ;
        @(posedge clk);
        succ = br_pred_vld && br_pred_succ;
        if (rst_n) begin
            foreach (mq[i]) begin
                if (!(i == 0 && exp_done) && !sq(mq[i].level)) begin
                    e = mq[i];
                    if (succ) e.level = nxt_of(e.level);
                    e.age++;
                    nq.push_back(e);
                end
            end
            if (in_vld && exp_in_rdy && !sq(int'(in_spec_level))) begin
                e.id    = in_id;
                e.data  = in_data;
                e.addr  = 16'(int'(in_base) + int'($signed(in_ofs)));
                e.level = succ ? nxt_of(int'(in_spec_level)) : int'(in_spec_level);
                e.age   = 1;
                nq.push_back(e);
            end
            mq = nq;
        end else begin
            mq.delete();
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle_check();
        advance();
    endtask

    task automatic present(input logic [7:0] id, input logic [15:0] base, input logic [7:0] ofs,
                           input logic [15:0] data, input logic [2:0] lvl);
        in_vld = 1'b1; in_id = id; in_base = base; in_ofs = ofs; in_data = data; in_spec_level = lvl;
    endtask

    task automatic br_idle();
        br_pred_vld = 1'b0; br_pred_succ = 1'b0; br_pred_fail_level = '0;
    endtask

    initial begin
        int acc;
        int k;
        rst_n = 1'b0; in_vld = 1'b0; in_id = '0; in_base = '0; in_ofs = '0; in_data = '0;
        in_spec_level = '0; out_rdy = 1'b1; br_idle();
        br_pred_succ_nxt_levels = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        @(negedge clk);
        settle_check();
        chk("reset_in_rdy", 32'(in_rdy), 32'd1);
        chk("reset_out_vld", 32'(out_vld), 32'd0);
        chk("reset_done_vld", 32'(done_vld), 32'd0);
        advance();
        rst_n = 1'b1;
        tick();

        // Negative offset, two-cycle latency.
        present(8'd1, 16'h1000, 8'hFC, 16'hAAAA, 3'd0);
        tick();
        in_vld = 1'b0;
        settle_check();
        chk("lat_t1_out_vld", 32'(out_vld), 32'd0);
        advance();
        settle_check();
        chk("lat_t2_out_vld", 32'(out_vld), 32'd1);
        chk("neg_ofs_addr", 32'(out_addr), 32'h0FFC);
        chk("lat_t2_done", 32'(done_vld), 32'd1);
        chk("lat_t2_done_id", 32'(done_id), 32'd1);
        advance();

        // Address wrap.
        present(8'd2, 16'hFFFE, 8'h05, 16'h5555, 3'd0);
        tick();
        in_vld = 1'b0;
        tick();
        settle_check();
        chk("wrap_addr", 32'(out_addr), 32'h0003);
        advance();
        repeat (2) tick();

        // Backpressure: 4 back-to-back stores, out_rdy low for 5 cycles.
        emitted.delete();
        out_rdy = 1'b0; k = 0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            present(8'(10 + k), 16'h2000 + 16'(k), 8'(k), 16'(k * 3), 3'd0);
            settle_check();
            if (in_rdy) begin acc++; k++; end
            advance();
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            present(8'(10 + k), 16'h2000 + 16'(k), 8'(k), 16'(k * 3), 3'd0);
            settle_check();
            if (in_rdy) k++;
            advance();
        end
        chk("bp_all_issued", 32'(k), 32'd4);
        in_vld = 1'b0;
        repeat (6) tick();
        chk("bp_emit_count", 32'(emitted.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < emitted.size()) chk("bp_emit_order", 32'(emitted[i]), 32'(10 + i));
        end

        // Fail squashes B (level 2) while A (level 1) survives.
        out_rdy = 1'b0;
        present(8'd20, 16'h3000, 8'h00, 16'h0020, 3'd2);
        tick();
        present(8'd21, 16'h3100, 8'h00, 16'h0021, 3'd1);
        tick();
        in_vld = 1'b0;
        out_rdy = 1'b1;
        br_pred_vld = 1'b1; br_pred_succ = 1'b0; br_pred_fail_level = 3'd2;
        settle_check();
        chk("fail_out_vld", 32'(out_vld), 32'd0);
        chk("fail_done_vld", 32'(done_vld), 32'd0);
        advance();
        br_idle();
        settle_check();
        chk("fail_survivor_vld", 32'(out_vld), 32'd1);
        chk("fail_survivor_id", 32'(out_id), 32'd21);
        advance();
        repeat (2) tick();

        // Succ remap on handshake cycle and for incoming store.
        out_rdy = 1'b0;
        present(8'd30, 16'h4000, 8'h00, 16'h0030, 3'd3);
        tick();
        in_vld = 1'b0;
        tick();
        out_rdy = 1'b1;
        br_pred_succ_nxt_levels = {3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        br_pred_vld = 1'b1; br_pred_succ = 1'b1;
        present(8'd31, 16'h4100, 8'h00, 16'h0031, 3'd1);
        settle_check();
        chk("succ_out_level", 32'(out_spec_level), 32'd2);
        chk("succ_done", 32'(done_vld), 32'd1);
        advance();
        in_vld = 1'b0;
        br_idle();
        tick();
        settle_check();
        chk("succ_incoming_id", 32'(out_id), 32'd31);
        chk("succ_incoming_level", 32'(out_spec_level), 32'd0);
        advance();
        repeat (2) tick();

        // Reset with both stages full.
        out_rdy = 1'b0;
        present(8'd40, 16'h5000, 8'h00, 16'h0040, 3'd0);
        tick();
        present(8'd41, 16'h5100, 8'h00, 16'h0041, 3'd0);
        tick();
        in_vld = 1'b0;
        out_rdy = 1'b1;
        rst_n = 1'b0;
        mq.delete();
        settle_check();
        chk("rst_mid_out_vld", 32'(out_vld), 32'd0);
        chk("rst_mid_done_vld", 32'(done_vld), 32'd0);
        advance();
        rst_n = 1'b1;
        emitted.delete();
        settle_check();
        chk("rst_rel_in_rdy", 32'(in_rdy), 32'd1);
        advance();
        repeat (4) tick();
        chk("rst_nothing_emitted", 32'(emitted.size()), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_vld        = ($urandom_range(99) < 65);
            in_id         = 8'($urandom);
            in_base       = 16'($urandom);
            in_ofs        = 8'($urandom);
            in_data       = 16'($urandom);
            in_spec_level = 3'($urandom_range(4));
            out_rdy       = ($urandom_range(99) < 70);
            br_idle();
            if ($urandom_range(99) < 15) begin
                br_pred_vld        = 1'b1;
                br_pred_succ       = 1'($urandom_range(1));
                br_pred_fail_level = 3'($urandom_range(4, 1));
                for (int i = 0; i < 5; i++)
                    br_pred_succ_nxt_levels[i*3 +: 3] = 3'($urandom_range(4));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
